// File: rtl/pipeline_if_queue_stage.sv
// rtl/pipeline_if_queue_stage.sv - instruction fetch stage with prefetch queue and redirect flush
// Requests go out in order; responses fill the oldest unfilled entry and the head entry feeds ID.
module pipeline_if_queue_stage #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            im_req_valid,
  input  logic            im_req_ready,
  output logic [XLEN-1:0] im_addr,
  input  logic            im_resp_valid,
  input  logic [ILEN-1:0] im_dout,
  output logic            if_valid,
  output logic [XLEN-1:0] pc_IF,
  output logic [ILEN-1:0] instruction_IF
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW:0] QDEPTH_W = (PW + 1)'(QDEPTH);

  logic [XLEN-1:0]   ent_pc_q    [QDEPTH];
  logic [ILEN-1:0]   ent_instr_q [QDEPTH];
  logic [QDEPTH-1:0] ent_filled_q;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [PW-1:0] alloc;
  logic [PW-1:0] outstanding;
  logic [PW-1:0] pending;
  logic [PW:0]   credit_sum;
  logic          credit;
  logic          req_fire;
  logic          resp_drop;
  logic          resp_fill;
  logic          pop;
  logic [AW-1:0] rd_idx, wr_idx, fill_idx;
  logic          unused_tgt_lsb;

  assign unused_tgt_lsb = ^branch_target[1:0];

  assign rd_idx   = rd_ptr_q[AW-1:0];
  assign wr_idx   = wr_ptr_q[AW-1:0];
  assign fill_idx = fill_ptr_q[AW-1:0];

  // Pointers wrap modulo 2*QDEPTH, so plain subtraction gives occupancy.
  assign alloc       = wr_ptr_q - rd_ptr_q;
  assign outstanding = wr_ptr_q - fill_ptr_q;

  // Responses still owed for flushed requests occupy memory slots, so they consume credit too.
  assign credit_sum = {1'b0, alloc} + {1'b0, drop_cnt_q};
  assign credit     = credit_sum < QDEPTH_W;

  assign im_req_valid = !reset && !branch_taken && credit;
  assign im_addr      = fetch_pc_q;

  assign if_valid       = ent_filled_q[rd_idx];
  assign pc_IF          = if_valid ? ent_pc_q[rd_idx] : '0;
  assign instruction_IF = if_valid ? ent_instr_q[rd_idx] : '0;

  assign req_fire  = im_req_valid && im_req_ready;
  assign resp_drop = im_resp_valid && (drop_cnt_q != '0);
  assign resp_fill = im_resp_valid && (drop_cnt_q == '0) && (outstanding != '0);
  assign pop       = if_valid && !stall && !branch_taken;
  assign pending   = drop_cnt_q + outstanding;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fill_ptr_d = fill_ptr_q;
    drop_cnt_d = drop_cnt_q;
    if (branch_taken) begin
      fetch_pc_d = {branch_target[XLEN-1:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fill_ptr_d = '0;
      // A response in the redirect cycle belongs to a stale request and retires one owed slot.
      drop_cnt_d = (im_resp_valid && (pending != '0)) ? pending - PW'(1) : pending;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        wr_ptr_d   = wr_ptr_q + PW'(1);
      end
      if (resp_drop) begin
        drop_cnt_d = drop_cnt_q - PW'(1);
      end
      if (resp_fill) begin
        fill_ptr_d = fill_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Entry indices touched in one cycle never collide: a request needs a free slot,
  // a fill targets an allocated unfilled slot and a pop targets a filled one.
  always_ff @(posedge clk) begin
    if (reset || branch_taken) begin
      ent_filled_q <= '0;
    end else begin
      if (req_fire) begin
        ent_filled_q[wr_idx] <= 1'b0;
      end
      if (resp_fill) begin
        ent_filled_q[fill_idx] <= 1'b1;
      end
      if (pop) begin
        ent_filled_q[rd_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      ent_pc_q[wr_idx] <= fetch_pc_q;
    end
    if (resp_fill) begin
      ent_instr_q[fill_idx] <= im_dout;
    end
  end

endmodule

// File: tb/tb_pipeline_if_queue_stage.sv
// tb/tb_pipeline_if_queue_stage.sv - scoreboard bench for pipeline_if_queue_stage
module tb_pipeline_if_queue_stage;

  localparam int XLEN   = 64;
  localparam int ILEN   = 32;
  localparam int QDEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            im_req_valid;
  logic            im_req_ready;
  logic [XLEN-1:0] im_addr;
  logic            im_resp_valid;
  logic [ILEN-1:0] im_dout;
  logic            if_valid;
  logic [XLEN-1:0] pc_IF;
  logic [ILEN-1:0] instruction_IF;

  always #5 clk = ~clk;

  pipeline_if_queue_stage #(
    .XLEN(XLEN), .ILEN(ILEN), .RESET_PC('0), .QDEPTH(QDEPTH)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .im_req_valid(im_req_valid), .im_req_ready(im_req_ready), .im_addr(im_addr),
    .im_resp_valid(im_resp_valid), .im_dout(im_dout),
    .if_valid(if_valid), .pc_IF(pc_IF), .instruction_IF(instruction_IF)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int lat = 1;
  int req_count = 0;
  logic [XLEN-1:0] exp_pc [$];
  logic [XLEN-1:0] pend_a [$];
  int              pend_due [$];

  function automatic logic [ILEN-1:0] instr_of(input logic [XLEN-1:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // In-order memory: answers each accepted request lat cycles after acceptance.
  initial begin : mem
    logic            fire;
    logic [XLEN-1:0] a;
    int              cyc;
    cyc = 0;
    im_resp_valid = 1'b0;
    im_dout = '0;
    forever begin
      @(negedge clk);
      fire = im_req_valid && im_req_ready;
      a = im_addr;
      if (fire) req_count++;
      if (reset) begin
        pend_a.delete();
        pend_due.delete();
      end
      @(posedge clk);
      #1;
      cyc++;
      if (fire) begin
        pend_a.push_back(a);
        pend_due.push_back(cyc + lat - 1);
      end
      if (pend_a.size() > 0 && pend_due[0] <= cyc) begin
        im_resp_valid = 1'b1;
        im_dout = instr_of(pend_a.pop_front());
        void'(pend_due.pop_front());
      end else begin
        im_resp_valid = 1'b0;
        im_dout = '0;
      end
    end
  end

  // Monitor: every retired head entry is compared against the scoreboard.
  initial begin : mon
    logic [XLEN-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset && if_valid && !stall && !branch_taken && exp_pc.size() > 0) begin
        e = exp_pc.pop_front();
        check("pop_pc", pc_IF, e);
        check("pop_instr", 64'(instruction_IF), 64'(instr_of(e)));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    branch_taken = 1'b0;
    exp_pc.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_pc.size() > 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    check(name, 64'(exp_pc.size()), 64'd0);
  endtask

  task automatic wait_reqs(input int n, input string name);
    int base;
    int k;
    base = req_count;
    k = 0;
    while (req_count - base < n && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(name, 64'(req_count - base), 64'(n));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int b;
    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    im_req_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_valid", if_valid, 0);
    check("rst_req_valid", im_req_valid, 0);
    check("rst_pc_IF", pc_IF, 0);
    check("rst_instr", 64'(instruction_IF), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Streaming fetch, 1-cycle latency
    for (int i = 0; i < 8; i++) exp_pc.push_back(64'(4 * i));
    @(negedge clk);
    check("t1_valid_c0", if_valid, 0);
    check("t1_req_c0", im_req_valid, 1);
    check("t1_addr_c0", im_addr, 64'h0);
    @(negedge clk);
    check("t1_valid_c1", if_valid, 0);
    check("t1_addr_c1", im_addr, 64'h4);
    @(negedge clk);
    check("t1_valid_c2", if_valid, 1);
    drain("t1_drain");

    // Stall held: queue fills to QDEPTH, refetch only after first pop
    stall = 1'b1;
    lat = 1;
    do_reset();
    b = req_count;
    repeat (10) @(negedge clk);
    check("t2_req_count", 64'(req_count - b), 64'd4);
    check("t2_full_req_valid", im_req_valid, 0);
    check("t2_head_pc", pc_IF, 64'h0);
    check("t2_head_instr", 64'(instruction_IF), 64'(instr_of(64'h0)));
    for (int i = 0; i < 6; i++) exp_pc.push_back(64'(4 * i));
    @(posedge clk);
    #1;
    stall = 1'b0;
    @(negedge clk);
    check("t2_no_credit_on_pop", im_req_valid, 0);
    @(negedge clk);
    check("t2_refetch_valid", im_req_valid, 1);
    check("t2_refetch_addr", im_addr, 64'h10);
    check("t2_next_head_valid", if_valid, 1);
    drain("t2_drain");

    // Redirect with 3 requests outstanding at 5-cycle latency
    lat = 5;
    do_reset();
    wait_reqs(3, "t3_three_reqs");
    @(posedge clk);
    #1;
    branch_taken = 1'b1;
    branch_target = 64'h1002;
    @(negedge clk);
    check("t3_req_withdrawn", im_req_valid, 0);
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    for (int i = 0; i < 4; i++) exp_pc.push_back(64'h1000 + 64'(4 * i));
    @(negedge clk);
    check("t3_new_addr", im_addr, 64'h1000);
    check("t3_new_req", im_req_valid, 1);
    check("t3_flushed", if_valid, 0);
    drain("t3_drain");

    // Redirect coinciding with a response and a pop
    lat = 2;
    do_reset();
    wait_reqs(3, "t4_three_reqs");
    @(posedge clk);
    #1;
    branch_taken = 1'b1;
    branch_target = 64'h2000;
    @(negedge clk);
    check("t4_head_valid", if_valid, 1);
    check("t4_resp_same_cycle", im_resp_valid, 1);
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) exp_pc.push_back(64'h2000 + 64'(4 * i));
    @(negedge clk);
    check("t4_pop_suppressed", if_valid, 0);
    check("t4_new_addr", im_addr, 64'h2000);
    drain("t4_drain");

    // Back-pressure on requests, then mid-stream reset
    lat = 1;
    im_req_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_req_held", im_req_valid, 1);
      check("t5_addr_held", im_addr, 64'h0);
    end
    @(posedge clk);
    #1;
    im_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_pc.push_back(64'(4 * i));
    @(negedge clk);
    check("t5_addr_after_ready", im_addr, 64'h0);
    drain("t5_drain");
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_pc.delete();
    @(negedge clk);
    check("t5_rst_req_valid", im_req_valid, 0);
    @(negedge clk);
    check("t5_rst_if_valid", if_valid, 0);
    check("t5_rst_pc_IF", pc_IF, 0);
    check("t5_rst_instr", 64'(instruction_IF), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) exp_pc.push_back(64'(4 * i));
    @(negedge clk);
    check("t5_restart_addr", im_addr, 64'h0);
    check("t5_restart_req", im_req_valid, 1);
    drain("t5_restart_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
